// File: rtl/candy_sram_arb_pkg.sv
// Shared types and widths for the data-SRAM arbiter.
// State encodings are fixed so they line up with external debug views of the FSM.
package candy_sram_arb_pkg;

    localparam int SRAM_ADDR_W = 16;
    localparam int SRAM_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/candy_sram_arb_if.sv
// Requester bus plus SRAM pins of the data-SRAM arbiter.
// The "slave" modport is the arbiter's view; "master" is the requester/SRAM side.
interface candy_sram_arb_if
    import candy_sram_arb_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int DATA_W = SRAM_DATA_W
);
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        we;
    logic [NREQ*ADDR_W-1:0] addr;
    logic [NREQ*DATA_W-1:0] wdata;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        done;
    logic [DATA_W-1:0]      rdata;
    logic                   busy;
    logic                   sram_ce;
    logic                   sram_we;
    logic [ADDR_W-1:0]      sram_addr;
    logic [DATA_W-1:0]      sram_wdata;
    logic [DATA_W-1:0]      sram_rdata;

    modport master (
        output req, we, addr, wdata, sram_rdata,
        input  gnt, done, rdata, busy, sram_ce, sram_we, sram_addr, sram_wdata
    );

    modport slave (
        input  req, we, addr, wdata, sram_rdata,
        output gnt, done, rdata, busy, sram_ce, sram_we, sram_addr, sram_wdata
    );
endinterface

// File: rtl/candy_sram_arb_rr_pick.sv
// Combinational round-robin picker: first set request after the last winner,
// optionally overridden by a fixed priority for requester 0.
module candy_sram_arb_rr_pick #(
    parameter int NREQ    = 3,
    parameter int P0_PRIO = 0,
    parameter int IDX_W   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last,
    output logic [NREQ-1:0]  pick_oh,
    output logic [IDX_W-1:0] pick_idx
);

    logic             found_s;
    logic [IDX_W-1:0] cand_s;

    // Scan last+1 .. last+NREQ modulo NREQ and keep the first hit.
    always_comb begin
        found_s  = 1'b0;
        cand_s   = '0;
        pick_idx = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand_s = IDX_W'((int'(last) + i) % NREQ);
            if (!found_s && req[cand_s]) begin
                found_s  = 1'b1;
                pick_idx = cand_s;
            end else begin
                found_s  = found_s;
            end
        end
        if ((P0_PRIO != 0) && req[0]) begin
            pick_idx = '0;
        end else begin
            pick_idx = pick_idx;
        end
        pick_oh           = '0;
        pick_oh[pick_idx] = 1'b1;
    end

endmodule

// File: rtl/candy_sram_arb.sv
// Arbiter and access sequencer for the single-port data SRAM: one request at a
// time, a fixed-length SRAM window, then a one-cycle done pulse with read data.
module candy_sram_arb
    import candy_sram_arb_pkg::*;
#(
    parameter int NREQ          = 3,
    parameter int ADDR_W        = SRAM_ADDR_W,
    parameter int DATA_W        = SRAM_DATA_W,
    parameter int ACCESS_CYCLES = 2,
    parameter int P0_PRIO       = 0
) (
    input  logic              clk,
    input  logic              rst,
    candy_sram_arb_if.slave   bus
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(ACCESS_CYCLES) + 1;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic [NREQ-1:0]     done_q, done_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                busy_q, busy_d;
    logic                sram_ce_q, sram_ce_d;
    logic                sram_we_q, sram_we_d;
    logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
    logic [DATA_W-1:0]   sram_wdata_q, sram_wdata_d;

    logic [NREQ-1:0]     pick_oh_s;
    logic [IDX_W-1:0]    pick_idx_s;

    candy_sram_arb_rr_pick #(
        .NREQ    (NREQ),
        .P0_PRIO (P0_PRIO),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req      (bus.req),
        .last     (last_q),
        .pick_oh  (pick_oh_s),
        .pick_idx (pick_idx_s)
    );

    // The SRAM pin registers double as the operand latch for the access window;
    // last_q is both the round-robin pointer and the index of the active requester.
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        gnt_d        = '0;
        done_d       = '0;
        rdata_d      = rdata_q;
        sram_ce_d    = sram_ce_q;
        sram_we_d    = sram_we_q;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    state_d      = ST_ACCESS;
                    last_d       = pick_idx_s;
                    cnt_d        = CNT_W'(ACCESS_CYCLES - 1);
                    gnt_d        = pick_oh_s;
                    sram_ce_d    = 1'b1;
                    sram_we_d    = bus.we[pick_idx_s];
                    sram_addr_d  = bus.addr[pick_idx_s*ADDR_W +: ADDR_W];
                    sram_wdata_d = bus.wdata[pick_idx_s*DATA_W +: DATA_W];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == CNT_W'(0)) begin
                    if (!sram_we_q) begin
                        rdata_d = bus.sram_rdata;
                    end else begin
                        rdata_d = rdata_q;
                    end
                    state_d          = ST_DONE;
                    done_d[last_q]   = 1'b1;
                    sram_ce_d        = 1'b0;
                    sram_we_d        = 1'b0;
                    sram_addr_d      = '0;
                    sram_wdata_d     = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d      = ST_IDLE;
                sram_ce_d    = 1'b0;
                sram_we_d    = 1'b0;
                sram_addr_d  = '0;
                sram_wdata_d = '0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            last_q       <= IDX_W'(NREQ - 1);
            cnt_q        <= '0;
            gnt_q        <= '0;
            done_q       <= '0;
            rdata_q      <= '0;
            busy_q       <= 1'b0;
            sram_ce_q    <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
            gnt_q        <= gnt_d;
            done_q       <= done_d;
            rdata_q      <= rdata_d;
            busy_q       <= busy_d;
            sram_ce_q    <= sram_ce_d;
            sram_we_q    <= sram_we_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.done       = done_q;
    assign bus.rdata      = rdata_q;
    assign bus.busy       = busy_q;
    assign bus.sram_ce    = sram_ce_q;
    assign bus.sram_we    = sram_we_q;
    assign bus.sram_addr  = sram_addr_q;
    assign bus.sram_wdata = sram_wdata_q;

endmodule

// File: tb/tb_candy_sram_arb.sv
// Scoreboard bench for candy_sram_arb: a round-robin build (ACCESS_CYCLES=2) and
// a priority build (P0_PRIO=1, ACCESS_CYCLES=1) each with a behavioural SRAM.
module tb_candy_sram_arb;
    import candy_sram_arb_pkg::*;

    localparam int NREQ = 3;
    localparam int AW   = 16;
    localparam int DW   = 32;

    typedef struct {
        int          id;
        bit          we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gap;
        int          gcyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    exp_t exp_a[$], exp_b[$], pend_a[$], pend_b[$];
    int   last_gnt [2] = '{0, 0};
    int   gcnt     [2] = '{0, 0};
    int   ce_cnt   [2] = '{0, 0};
    logic [31:0] last_rd [2] = '{32'h0, 32'h0};

    candy_sram_arb_if #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) ifa ();
    candy_sram_arb_if #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) ifb ();

    candy_sram_arb #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(2), .P0_PRIO(0))
        dut_a (.clk(clk), .rst(rst), .bus(ifa));
    candy_sram_arb #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(1), .P0_PRIO(1))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));

    function automatic logic [31:0] pat(input logic [15:0] a);
        if (a == 16'h0020) return 32'h12345678;
        return {16'hC0DE, a};
    endfunction

    // Behavioural SRAMs: unwritten words read back as pat(addr).
    logic [31:0]  mem_a [256];
    logic [31:0]  mem_b [256];
    logic [255:0] vld_a, vld_b;
    always @(posedge clk or negedge rst)
        if (!rst) begin vld_a <= '0; vld_b <= '0; end
        else begin
            if (ifa.sram_ce && ifa.sram_we) vld_a[ifa.sram_addr[7:0]] <= 1'b1;
            if (ifb.sram_ce && ifb.sram_we) vld_b[ifb.sram_addr[7:0]] <= 1'b1;
        end
    always @(posedge clk) begin
        if (ifa.sram_ce && ifa.sram_we) mem_a[ifa.sram_addr[7:0]] <= ifa.sram_wdata;
        if (ifb.sram_ce && ifb.sram_we) mem_b[ifb.sram_addr[7:0]] <= ifb.sram_wdata;
    end
    assign ifa.sram_rdata = (ifa.sram_ce && !ifa.sram_we) ?
        (vld_a[ifa.sram_addr[7:0]] ? mem_a[ifa.sram_addr[7:0]] : pat(ifa.sram_addr)) : 32'hBAD0BAD0;
    assign ifb.sram_rdata = (ifb.sram_ce && !ifb.sram_we) ?
        (vld_b[ifb.sram_addr[7:0]] ? mem_b[ifb.sram_addr[7:0]] : pat(ifb.sram_addr)) : 32'hBAD0BAD0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic expect_acc(input int d, input int id, input bit w, input logic [15:0] a,
                              input logic [31:0] wd, input logic [31:0] rd, input int gap);
        exp_t e;
        e.id = id; e.we = w; e.addr = a; e.wdata = wd; e.rdata = rd; e.gap = gap; e.gcyc = 0;
        if (d == 0) exp_a.push_back(e);
        else        exp_b.push_back(e);
    endtask

    task automatic drv(input int d, input int i, input bit w, input logic [15:0] a, input logic [31:0] wd);
        if (d == 0) begin
            ifa.req[i] = 1'b1; ifa.we[i] = w; ifa.addr[i*AW +: AW] = a; ifa.wdata[i*DW +: DW] = wd;
        end else begin
            ifb.req[i] = 1'b1; ifb.we[i] = w; ifb.addr[i*AW +: AW] = a; ifb.wdata[i*DW +: DW] = wd;
        end
    endtask

    task automatic mon(input int d, input logic [2:0] gnt, input logic [2:0] done, input logic ce,
                       input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdata, input int ac);
        exp_t e;
        bit   have;
        if (gnt != 3'b000) begin
            have = 1'b0;
            if (d == 0 && exp_a.size() > 0) begin e = exp_a.pop_front(); have = 1'b1; end
            if (d == 1 && exp_b.size() > 0) begin e = exp_b.pop_front(); have = 1'b1; end
            if (!have) chk("gnt_unexpected", 64'(gnt), 64'd0);
            else begin
                chk("gnt", 64'(gnt), 64'd1 << e.id);
                chk("gnt_ce", 64'(ce), 64'd1);
                chk("gnt_we", 64'(we), 64'(e.we));
                chk("gnt_addr", 64'(addr), 64'(e.addr));
                if (e.we) chk("gnt_wdata", 64'(wdata), 64'(e.wdata));
                if (e.gap != 0) chk("gnt_gap", 64'(cyc - last_gnt[d]), 64'(e.gap));
                last_gnt[d] = cyc;
                gcnt[d]++;
                e.gcyc = cyc;
                if (d == 0) pend_a.push_back(e);
                else        pend_b.push_back(e);
            end
        end
        if (ce) begin
            ce_cnt[d]++;
            if (d == 0 && pend_a.size() > 0) chk("hold_addr", 64'(addr), 64'(pend_a[0].addr));
            if (d == 1 && pend_b.size() > 0) chk("hold_addr", 64'(addr), 64'(pend_b[0].addr));
        end
        if (done != 3'b000) begin
            have = 1'b0;
            if (d == 0 && pend_a.size() > 0) begin e = pend_a.pop_front(); have = 1'b1; end
            if (d == 1 && pend_b.size() > 0) begin e = pend_b.pop_front(); have = 1'b1; end
            if (!have) chk("done_unexpected", 64'(done), 64'd0);
            else begin
                chk("done", 64'(done), 64'd1 << e.id);
                chk("done_lat", 64'(cyc - e.gcyc), 64'(ac));
                chk("ce_cycles", 64'(ce_cnt[d]), 64'(ac));
                chk("done_ce", 64'({ce, we}), 64'd0);
                if (!e.we) begin
                    chk("rdata", 64'(rdata), 64'(e.rdata));
                    last_rd[d] = e.rdata;
                end else begin
                    chk("rdata_hold", 64'(rdata), 64'(last_rd[d]));
                end
            end
            ce_cnt[d] = 0;
        end
    endtask

    always @(negedge clk) mon(0, ifa.gnt, ifa.done, ifa.sram_ce, ifa.sram_we, ifa.sram_addr, ifa.sram_wdata, ifa.rdata, 2);
    always @(negedge clk) mon(1, ifb.gnt, ifb.done, ifb.sram_ce, ifb.sram_we, ifb.sram_addr, ifb.sram_wdata, ifb.rdata, 1);

    task automatic wait_gnt(input int d, input int n);
        for (int k = 0; k < 60 && gcnt[d] < n; k++) begin @(negedge clk); #1; end
        chk("wait_gnt", 64'(gcnt[d]), 64'(n));
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 60 && (pend_a.size() + pend_b.size() + exp_a.size() + exp_b.size() != 0
                                   || ifa.busy || ifb.busy); k++) begin
            @(negedge clk); #1;
        end
        chk("idle", 64'({ifa.busy, ifb.busy}), 64'd0);
    endtask

    task automatic clear_bench_state();
        pend_a.delete(); pend_b.delete();
        ce_cnt[0] = 0; ce_cnt[1] = 0;
        last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    endtask

    initial begin
        int t0;
        ifa.req = '0; ifa.we = '0; ifa.addr = '0; ifa.wdata = '0;
        ifb.req = '0; ifb.we = '0; ifb.addr = '0; ifb.wdata = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_outs_a", {ifa.gnt, ifa.done, ifa.busy, ifa.sram_ce, ifa.sram_we}, 64'd0);
        chk("rst_sram_a", {ifa.sram_addr, ifa.sram_wdata}, 64'd0);
        chk("rst_rdata_a", 64'(ifa.rdata), 64'd0);
        chk("rst_outs_b", {ifb.gnt, ifb.done, ifb.busy, ifb.sram_ce}, 64'd0);
        rst = 1'b1;
        @(negedge clk); #1;

        // Single write from requester 1.
        expect_acc(0, 1, 1'b1, 16'h0010, 32'hDEADBEEF, 32'h0, 0);
        drv(0, 1, 1'b1, 16'h0010, 32'hDEADBEEF);
        t0 = cyc;
        wait_gnt(0, 1);
        chk("gnt_lat", 64'(cyc - t0), 64'd1);
        ifa.req = '0;
        wait_idle();

        // Single read from requester 2, then a write that must leave rdata alone.
        expect_acc(0, 2, 1'b0, 16'h0020, 32'h0, 32'h12345678, 0);
        drv(0, 2, 1'b0, 16'h0020, 32'h0);
        wait_gnt(0, 2);
        ifa.req = '0;
        wait_idle();
        expect_acc(0, 0, 1'b1, 16'h0030, 32'hCAFEF00D, 32'h0, 0);
        drv(0, 0, 1'b1, 16'h0030, 32'hCAFEF00D);
        wait_gnt(0, 3);
        ifa.req = '0;
        wait_idle();
        expect_acc(0, 1, 1'b0, 16'h0010, 32'h0, 32'hDEADBEEF, 0);
        drv(0, 1, 1'b0, 16'h0010, 32'h0);
        wait_gnt(0, 4);
        ifa.req = '0;
        wait_idle();

        // Fresh reset, then all three request continuously: order 0,1,2,0 four cycles apart.
        rst = 1'b0; clear_bench_state();
        repeat (2) @(negedge clk);
        rst = 1'b1; #1;
        for (int i = 0; i < 3; i++) drv(0, i, 1'b0, 16'h0040 + 16'(i), 32'h0);
        expect_acc(0, 0, 1'b0, 16'h0040, 32'h0, pat(16'h0040), 0);
        expect_acc(0, 1, 1'b0, 16'h0041, 32'h0, pat(16'h0041), 4);
        expect_acc(0, 2, 1'b0, 16'h0042, 32'h0, pat(16'h0042), 4);
        expect_acc(0, 0, 1'b0, 16'h0040, 32'h0, pat(16'h0040), 4);
        wait_gnt(0, 8);
        ifa.req = '0;
        wait_idle();

        // Priority build: requester 0 starves the rest until it drops, then 1 wins.
        for (int i = 0; i < 3; i++) drv(1, i, 1'b0, 16'h0050 + 16'(i), 32'h0);
        expect_acc(1, 0, 1'b0, 16'h0050, 32'h0, pat(16'h0050), 0);
        expect_acc(1, 0, 1'b0, 16'h0050, 32'h0, pat(16'h0050), 3);
        expect_acc(1, 0, 1'b0, 16'h0050, 32'h0, pat(16'h0050), 3);
        expect_acc(1, 1, 1'b0, 16'h0051, 32'h0, pat(16'h0051), 3);
        wait_gnt(1, 3);
        ifb.req[0] = 1'b0;
        wait_gnt(1, 4);
        ifb.req = '0;
        wait_idle();

        // Reset during the second ACCESS cycle aborts; pending req[2] wins afterwards.
        expect_acc(0, 0, 1'b0, 16'h0060, 32'h0, pat(16'h0060), 0);
        drv(0, 0, 1'b0, 16'h0060, 32'h0);
        wait_gnt(0, 9);
        ifa.req = '0;
        drv(0, 2, 1'b1, 16'h0070, 32'h600DF00D);
        @(posedge clk); #2;
        rst = 1'b0; #1;
        chk("abort_outs", {ifa.gnt, ifa.done, ifa.busy, ifa.sram_ce, ifa.sram_we}, 64'd0);
        chk("abort_sram", {ifa.sram_addr, ifa.sram_wdata}, 64'd0);
        chk("abort_rdata", 64'(ifa.rdata), 64'd0);
        clear_bench_state();
        repeat (3) @(negedge clk);
        #1;
        chk("abort_no_done", 64'(ifa.done), 64'd0);
        expect_acc(0, 2, 1'b1, 16'h0070, 32'h600DF00D, 32'h0, 0);
        rst = 1'b1;
        wait_gnt(0, 10);
        ifa.req = '0;
        wait_idle();

        chk("exp_a_drained", 64'(exp_a.size()), 64'd0);
        chk("exp_b_drained", 64'(exp_b.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/candy_sram_arb.md
Name: candy_sram_arb

Overview:
- Round-robin arbiter and access sequencer sharing the single-port data SRAM between NREQ requesters.
- Port 0 is the writeback store path, port 1 the load unit, port 2 the host/debug loader.
- Accepts one request at a time and latches its operands. Drives the SRAM for a fixed ACCESS_CYCLES window, then returns a one-cycle done pulse and, for reads, captured read data.

Parameters:
- NREQ, 3, number of requesters (2..8).
- ADDR_W, 16, SRAM address width (matches `SRAMAddrWidth`).
- DATA_W, 32, SRAM data width (matches `SRAMDataWidth`).
- ACCESS_CYCLES, 2, cycles the SRAM is held per access (>=1).
- P0_PRIO, 0, 1 = requester 0 always wins when requesting; 0 = pure round-robin.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester request level.
- we  in  NREQ  per-requester write(1)/read(0).
- addr  in  NREQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
- wdata  in  NREQ*DATA_W  packed write data, same packing.
- gnt  out  NREQ  one-hot, one-cycle accept pulse.
- done  out  NREQ  one-hot, one-cycle completion pulse.
- rdata  out  DATA_W  read data, valid while done is high for a read.
- busy  out  1  high in any state other than IDLE.
- sram_ce  out  1  SRAM chip enable.
- sram_we  out  1  SRAM write enable.
- sram_addr  out  ADDR_W  SRAM address.
- sram_wdata  out  DATA_W  SRAM write data.
- sram_rdata  in  DATA_W  SRAM read data, valid by the last ACCESS cycle.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; gnt, done, rdata, sram_* all 0; busy=0.
  - Round-robin pointer last=NREQ-1, so requester 0 wins first.
  - Reset mid-access aborts the access; no done is issued.
- All outputs are registered.
- States: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE:
  - If req is 0, stay.
  - Otherwise select winner w: requester 0 if P0_PRIO=1 and req[0]=1. Else the first set req bit scanning last+1, last+2, … modulo NREQ.
  - At that edge: latch we[w], addr[w], wdata[w] and index w; set last=w; load count=ACCESS_CYCLES-1; go to ACCESS.
- ACCESS:
  - sram_ce=1; sram_we=latched we; sram_addr and sram_wdata = latched values, held stable for the whole window.
  - gnt[w]=1 only in the first ACCESS cycle.
  - Count decrements each cycle. When count==0: if it is a read, capture sram_rdata into rdata; go to DONE.
- DONE:
  - sram_ce=0, sram_we=0; done[w]=1 for one cycle; rdata holds until the next read completes.
  - Go to IDLE.
- Timing: a request seen in IDLE at cycle C gives gnt at C+1, SRAM active C+1..C+ACCESS_CYCLES, done at C+ACCESS_CYCLES+1. Next arbitration is at C+ACCESS_CYCLES+2. Peak throughput is one access per ACCESS_CYCLES+2 cycles.
- Requester contract:
  - Hold req, we, addr and wdata stable until gnt is seen.
  - Drop req in the cycle after gnt. A req still high in IDLE is treated as a new request.
  - Changes to operands after acceptance have no effect.
- Simultaneous requests: only one is granted; losers keep req high and wait. Round-robin bounds the wait to NREQ-1 accesses when P0_PRIO=0.
- Requests arriving during ACCESS or DONE are ignored until IDLE.
- Pointer wrap: last=NREQ-1 scans from 0.
- ACCESS_CYCLES=1: ACCESS lasts one cycle, and gnt and the capture happen in the same cycle.
- Widths: the count register is $clog2(ACCESS_CYCLES)+1 bits; the index is $clog2(NREQ) bits.

Decomposition:
- Shared defines (candy_defines.v):
  - state encodings ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_DONE=2'd2;
  - SRAM width macros, already present.
- Sub-module candy_rr_pick: combinational, req vector and last pointer in, one-hot and index out.

Test Plan:
- Single write, ACCESS_CYCLES=2: req[1]=1, we=1, addr=0x0010, wdata=0xDEADBEEF at C -> gnt[1] at C+1; sram_ce/we=1 with addr 0x0010 at C+1..C+2; done[1] at C+3; no other port is driven.
- Single read: SRAM model returns 0x12345678 at addr 0x0020 for requester 2 -> rdata=0x12345678 with done[2] at C+3; rdata unchanged afterwards.
- All three requesting continuously after reset (P0_PRIO=0) -> grant order 0,1,2,0, each spaced 4 cycles apart.
- P0_PRIO=1 with req=3'b111 held -> requester 0 granted every access and the others starve; after req[0] drops, 1 is granted next.
- rst pulled low at the second ACCESS cycle -> all outputs 0 immediately, no done; after release a pending req[2] is granted via the pointer reset (0 and 1 idle).
- ACCESS_CYCLES=1 build: back-to-back requests -> gnt and capture in the same cycle, done one cycle later, 3-cycle spacing.
